ex_muldiv: RTL and testbench

Iterative RV32M/RV64M multiply/divide unit in the execute stage, alongside the single-cycle ALU. It accepts one M-extension operation at a time and computes it over XLEN cycles using radix-2 shift-add multiply and restoring divide. While the operation runs it stalls the pipeline through `hold_o`. Divide-by-zero and signed overflow finish in a single cycle with RISC-V-mandated results.

---
 rtl/ex_muldiv.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
//
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// One M-extension operation is processed at a time. A radix-2 shift-add
// multiplier and a restoring divider share one 2*XLEN-bit accumulator and
// take XLEN cycles per operation. Divide-by-zero and signed divide overflow
// bypass the iteration and finish straight away with the architecturally
// defined results.
//
// Ports
//   clk           : clock, rising edge
//   arst_n        : asynchronous active-low reset
//   start_i       : operation request, only looked at in IDLE
//   flush_i       : pipeline flush, aborts whatever is in flight
//   funct3_i      : M-extension funct3 (MUL..REMU)
//   op1_i         : rs1 value (multiplicand / dividend)
//   op2_i         : rs2 value (multiplier / divisor)
//   reg_w_addr_i  : destination register index
//   hold_o        : combinational pipeline stall request
//   busy_o        : high while iterating
//   valid_o       : one-cycle result strobe
//   reg_w_ena_o   : register-file write enable (same as valid_o)
//   reg_w_addr_o  : destination register captured at start
//   result_o      : result, held until the next result is produced
// ---------------------------------------------------------------------------
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_w_addr_i,
  output logic            hold_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic            reg_w_ena_o,
  output logic [4:0]      reg_w_addr_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Wide enough to hold the value XLEN itself.
  localparam int CW = $clog2(XLEN + 1);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  // funct3 encodings
  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t            state_reg,  state_next;
  logic [2:0]        funct3_reg, funct3_next;
  logic [4:0]        rd_reg,     rd_next;
  // Multiply: {partial product high, multiplier being shifted out}.
  // Divide:   {partial remainder,    dividend shifting into quotient}.
  logic [2*XLEN-1:0] acc_reg,    acc_next;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [XLEN-1:0]   opb_reg,    opb_next;
  logic [CW-1:0]     cnt_reg,    cnt_next;
  // Operand was signed and negative, i.e. its magnitude was taken.
  logic              neg1_reg,   neg1_next;
  logic              neg2_reg,   neg2_next;
  logic              valid_reg,  valid_next;
  logic [XLEN-1:0]   result_reg, result_next;

  // -------------------------------------------------------------------------
  // Request decode (IDLE side)
  // -------------------------------------------------------------------------
  logic            req_is_div;
  logic            op1_signed;
  logic            op2_signed;
  logic            op1_neg;
  logic            op2_neg;
  logic [XLEN-1:0] op1_mag;
  logic [XLEN-1:0] op2_mag;
  logic            div_by_zero;
  logic            div_overflow;
  logic [XLEN-1:0] special_result;

  always_comb begin
    req_is_div = funct3_i[2];
    op1_signed = (funct3_i == F_MULH) || (funct3_i == F_MULHSU) ||
                 (funct3_i == F_DIV)  || (funct3_i == F_REM);
    op2_signed = (funct3_i == F_MULH) || (funct3_i == F_DIV) ||
                 (funct3_i == F_REM);
    op1_neg    = op1_signed & op1_i[XLEN-1];
    op2_neg    = op2_signed & op2_i[XLEN-1];
    op1_mag    = op1_neg ? -op1_i : op1_i;
    op2_mag    = op2_neg ? -op2_i : op2_i;

    div_by_zero  = req_is_div && (op2_i == '0);
    // Only the signed forms (DIV, REM: funct3[0] == 0) can overflow.
    div_overflow = req_is_div && !funct3_i[0] &&
                   (op1_i == MOST_NEG) && (op2_i == ALL_ONES);

    // funct3[1] separates the remainder forms from the quotient forms.
    special_result = '0;
    if (div_by_zero) begin
      special_result = funct3_i[1] ? op1_i : ALL_ONES;
    end else if (div_overflow) begin
      special_result = funct3_i[1] ? '0 : op1_i;
    end
  end

  // -------------------------------------------------------------------------
  // One iteration of the datapath, computed from the current accumulator
  // -------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     rem_shift;
  logic              quot_bit;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    // Shift-add multiply: add the multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole accumulator right. The
    // carry out of the add becomes the new MSB.
    mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
               (acc_reg[0] ? {1'b0, opb_reg} : {(XLEN+1){1'b0}});
    mul_step = {mul_sum, acc_reg[XLEN-1:1]};

    // Restoring divide: bring the next dividend bit into the remainder and
    // subtract the divisor only if that does not go negative. The remainder
    // is always below the divisor afterwards, so XLEN bits suffice.
    rem_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    quot_bit  = (rem_shift >= {1'b0, opb_reg});
    rem_new   = quot_bit ? XLEN'(rem_shift - {1'b0, opb_reg})
                         : rem_shift[XLEN-1:0];
    div_step  = {rem_new, acc_reg[XLEN-2:0], quot_bit};

    acc_step = funct3_reg[2] ? div_step : mul_step;
  end

  // -------------------------------------------------------------------------
  // Final sign correction and result selection (applied to acc_step on the
  // last iteration so the result is registered on the same edge)
  // -------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quot_fixed;
  logic [XLEN-1:0]   rem_fixed;
  logic [XLEN-1:0]   final_result;

  always_comb begin
    // For unsigned operands the neg flags are 0, so a plain XOR covers
    // MULH, MULHSU and MULHU alike.
    prod_fixed = (neg1_reg ^ neg2_reg) ? -acc_step : acc_step;
    quot_fixed = (neg1_reg ^ neg2_reg) ? -acc_step[XLEN-1:0]
                                       : acc_step[XLEN-1:0];
    rem_fixed  = neg1_reg ? -acc_step[2*XLEN-1:XLEN]
                          : acc_step[2*XLEN-1:XLEN];

    case (funct3_reg)
      F_MUL:                     final_result = prod_fixed[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: final_result = prod_fixed[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             final_result = quot_fixed;
      default:                   final_result = rem_fixed;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state / control
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    funct3_next = funct3_reg;
    rd_next     = rd_reg;
    acc_next    = acc_reg;
    opb_next    = opb_reg;
    cnt_next    = cnt_reg;
    neg1_next   = neg1_reg;
    neg2_next   = neg2_reg;
    valid_next  = 1'b0;
    result_next = result_reg;
    hold_o      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          hold_o      = 1'b1;
          funct3_next = funct3_i;
          rd_next     = reg_w_addr_i;
          if (div_by_zero || div_overflow) begin
            result_next = special_result;
            valid_next  = 1'b1;
            state_next  = S_DONE;
          end else begin
            if (req_is_div) begin
              acc_next = {{XLEN{1'b0}}, op1_mag};
              opb_next = op2_mag;
            end else begin
              acc_next = {{XLEN{1'b0}}, op2_mag};
              opb_next = op1_mag;
            end
            neg1_next  = op1_neg;
            neg2_next  = op2_neg;
            cnt_next   = CW'(XLEN);
            state_next = S_CALC;
          end
        end
      end

      S_CALC: begin
        hold_o   = 1'b1;
        acc_next = acc_step;
        cnt_next = cnt_reg - CW'(1);
        // Counter reaches zero with this iteration: finish now so the
        // strobe lands exactly XLEN edges after the start edge.
        if (cnt_reg == CW'(1)) begin
          result_next = final_result;
          valid_next  = 1'b1;
          state_next  = S_DONE;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // A flush wins over everything: back to IDLE, no strobe, and the last
    // delivered result stays on result_o.
    if (flush_i) begin
      state_next  = S_IDLE;
      valid_next  = 1'b0;
      result_next = result_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg  <= S_IDLE;
      funct3_reg <= '0;
      rd_reg     <= '0;
      acc_reg    <= '0;
      opb_reg    <= '0;
      cnt_reg    <= '0;
      neg1_reg   <= 1'b0;
      neg2_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      funct3_reg <= funct3_next;
      rd_reg     <= rd_next;
      acc_reg    <= acc_next;
      opb_reg    <= opb_next;
      cnt_reg    <= cnt_next;
      neg1_reg   <= neg1_next;
      neg2_reg   <= neg2_next;
      valid_reg  <= valid_next;
      result_reg <= result_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy_o       = (state_reg == S_CALC);
  assign valid_o      = valid_reg;
  assign reg_w_ena_o  = valid_reg;
  assign reg_w_addr_o = rd_reg;
  assign result_o     = result_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv
//
// Directed bench for ex_muldiv with one instance at XLEN=32 and one at
// XLEN=64. Each scenario task drives its own stimulus and compares the
// observed outputs against hand-computed values (or, for the 64-bit random
// ops, a behavioural arithmetic model).
//
// Latency convention used here: "lat" is the number of rising edges after
// the start edge E0 before valid_o is seen (XLEN for iterated ops, 0 for the
// single-step special cases whose strobe appears in the cycle right after
// the start cycle). "hcnt" counts the cycles after E0 with hold_o high.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- XLEN = 32 instance ----------------
  logic        start32, flush32;
  logic [2:0]  f3_32;
  logic [31:0] a32, b32;
  logic [4:0]  rd32;
  logic        hold32, busy32, valid32, ena32;
  logic [4:0]  rdo32;
  logic [31:0] res32;

  ex_muldiv #(.XLEN(32)) dut32 (
    .clk          (clk),
    .arst_n       (arst_n),
    .start_i      (start32),
    .flush_i      (flush32),
    .funct3_i     (f3_32),
    .op1_i        (a32),
    .op2_i        (b32),
    .reg_w_addr_i (rd32),
    .hold_o       (hold32),
    .busy_o       (busy32),
    .valid_o      (valid32),
    .reg_w_ena_o  (ena32),
    .reg_w_addr_o (rdo32),
    .result_o     (res32)
  );

  // ---------------- XLEN = 64 instance ----------------
  logic        start64, flush64;
  logic [2:0]  f3_64;
  logic [63:0] a64, b64;
  logic [4:0]  rd64;
  logic        hold64, busy64, valid64, ena64;
  logic [4:0]  rdo64;
  logic [63:0] res64;

  ex_muldiv #(.XLEN(64)) dut64 (
    .clk          (clk),
    .arst_n       (arst_n),
    .start_i      (start64),
    .flush_i      (flush64),
    .funct3_i     (f3_64),
    .op1_i        (a64),
    .op2_i        (b64),
    .reg_w_addr_i (rd64),
    .hold_o       (hold64),
    .busy_o       (busy64),
    .valid_o      (valid64),
    .reg_w_ena_o  (ena64),
    .reg_w_addr_o (rdo64),
    .result_o     (res64)
  );

  // ---------------- 64-bit reference model ----------------
  function automatic logic [63:0] ref64(input logic [2:0] f,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb;
    logic [63:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    case (f)
      3'd0: begin p = {64'd0, a} * {64'd0, b}; r = p[63:0]; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      3'd4: begin
        if (b == 64'd0) r = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
        else r = sa / sb;
      end
      3'd5: r = (b == 64'd0) ? '1 : a / b;
      3'd6: begin
        if (b == 64'd0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
        else r = sa % sb;
      end
      default: r = (b == 64'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  // ---------------- drivers ----------------
  // Start an op in the next cycle and wait (bounded) for the strobe. Returns
  // at the falling edge inside the cycle valid_o is high.
  task automatic run32(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       output logic [31:0] res, output logic [4:0] rdo,
                       output logic ena, output int lat, output int hcnt,
                       output logic hstart, output logic tmo);
    @(negedge clk);
    start32 = 1'b1; f3_32 = f; a32 = a; b32 = b; rd32 = rd;
    #1 hstart = hold32;
    @(posedge clk);
    #1 start32 = 1'b0;
    lat = 0; hcnt = 0; tmo = 1'b1; res = '0; rdo = '0; ena = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (valid32) begin
        tmo = 1'b0; res = res32; rdo = rdo32; ena = ena32;
        break;
      end
      if (hold32) hcnt++;
      @(posedge clk);
      lat++;
    end
    $display("op32 f3=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d", f, a, b, rd, res, lat);
  endtask

  task automatic run64(input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd,
                       output logic [63:0] res, output int lat,
                       output logic tmo);
    @(negedge clk);
    start64 = 1'b1; f3_64 = f; a64 = a; b64 = b; rd64 = rd;
    @(posedge clk);
    #1 start64 = 1'b0;
    lat = 0; tmo = 1'b1; res = '0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (valid64) begin
        tmo = 1'b0; res = res64;
        break;
      end
      @(posedge clk);
      lat++;
    end
    $display("op64 f3=%0d a=%h b=%h -> result=%h lat=%0d", f, a, b, res, lat);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst_n = 1'b0;
    start32 = 0; flush32 = 0; f3_32 = 0; a32 = 0; b32 = 0; rd32 = 0;
    start64 = 0; flush64 = 0; f3_64 = 0; a64 = 0; b64 = 0; rd64 = 0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({hold32, busy32, valid32, ena32} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl32: got %b expected 0000", {hold32, busy32, valid32, ena32});
    end
    n_checks++;
    if (rdo32 !== 5'd0 || res32 !== 32'd0) begin
      n_fail++; $display("FAIL reset_data32: got rd=%0d res=%h expected 0/0", rdo32, res32);
    end
    n_checks++;
    if ({hold64, busy64, valid64, ena64} !== 4'b0000 || res64 !== 64'd0) begin
      n_fail++; $display("FAIL reset64: got ctrl=%b res=%h expected 0", {hold64, busy64, valid64, ena64}, res64);
    end
    $display("reset released");
  endtask

  task automatic test_mul();
    logic [2:0]  tf [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] ta [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] tb [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] te [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] res; logic [4:0] rdo; logic ena, hs, tmo; int lat, hc;
    for (int i = 0; i < 4; i++) begin
      run32(tf[i], ta[i], tb[i], 5'(i + 5), res, rdo, ena, lat, hc, hs, tmo);
      n_checks++;
      if (tmo !== 1'b0 || res !== te[i]) begin
        n_fail++; $display("FAIL mul_result[%0d]: got %h (timeout=%b) expected %h", i, res, tmo, te[i]);
      end
      n_checks++;
      if (lat != 32 || hc != 32 || hs !== 1'b1) begin
        n_fail++; $display("FAIL mul_timing[%0d]: got lat=%0d hold=%0d hstart=%b expected 32/32/1", i, lat, hc, hs);
      end
      n_checks++;
      if (rdo !== 5'(i + 5) || ena !== 1'b1) begin
        n_fail++; $display("FAIL mul_wb[%0d]: got rd=%0d ena=%b expected %0d/1", i, rdo, ena, i + 5);
      end
      if (i == 0) begin
        @(negedge clk);
        n_checks++;
        if (valid32 !== 1'b0 || res32 !== te[0]) begin
          n_fail++; $display("FAIL mul_strobe_len: got valid=%b res=%h expected 0/%h", valid32, res32, te[0]);
        end
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  tf [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] ta [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] tb [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] te [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] res; logic [4:0] rdo; logic ena, hs, tmo; int lat, hc;
    for (int i = 0; i < 4; i++) begin
      run32(tf[i], ta[i], tb[i], 5'd12, res, rdo, ena, lat, hc, hs, tmo);
      n_checks++;
      if (tmo !== 1'b0 || res !== te[i]) begin
        n_fail++; $display("FAIL div_result[%0d]: got %h (timeout=%b) expected %h", i, res, tmo, te[i]);
      end
      n_checks++;
      if (lat != 32 || hc != 32) begin
        n_fail++; $display("FAIL div_timing[%0d]: got lat=%0d hold=%0d expected 32/32", i, lat, hc);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  tf [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] ta [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] te [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res; logic [4:0] rdo; logic ena, hs, tmo; int lat, hc;
    for (int i = 0; i < 4; i++) begin
      run32(tf[i], ta[i], tb[i], 5'(20 + i), res, rdo, ena, lat, hc, hs, tmo);
      n_checks++;
      if (tmo !== 1'b0 || res !== te[i]) begin
        n_fail++; $display("FAIL special_result[%0d]: got %h (timeout=%b) expected %h", i, res, tmo, te[i]);
      end
      n_checks++;
      if (lat != 0 || hc != 0 || hs !== 1'b1) begin
        n_fail++; $display("FAIL special_timing[%0d]: got lat=%0d hold_after=%0d hstart=%b expected 0/0/1", i, lat, hc, hs);
      end
      n_checks++;
      if (rdo !== 5'(20 + i) || ena !== 1'b1) begin
        n_fail++; $display("FAIL special_wb[%0d]: got rd=%0d ena=%b expected %0d/1", i, rdo, ena, 20 + i);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] rdo; logic ena, hs, tmo; int lat, hc;
    logic seen;
    // Known non-zero result on the output first.
    run32(3'd5, 32'd100, 32'd7, 5'd3, res, rdo, ena, lat, hc, hs, tmo);
    n_checks++;
    if (res !== 32'd14) begin
      n_fail++; $display("FAIL flush_pre: got %h expected %h", res, 32'd14);
    end
    @(negedge clk);
    start32 = 1'b1; f3_32 = 3'd4; a32 = 32'd1000; b32 = 32'd3; rd32 = 5'd9;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush32 = 1'b1;
    @(posedge clk);
    #1 flush32 = 1'b0;
    n_checks++;
    if ({busy32, valid32, hold32} !== 3'b000 || res32 !== 32'd14) begin
      n_fail++; $display("FAIL flush_abort: got busy/valid/hold=%b res=%h expected 000/%h", {busy32, valid32, hold32}, res32, 32'd14);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid32 || busy32) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || res32 !== 32'd14) begin
      n_fail++; $display("FAIL flush_quiet: got activity=%b res=%h expected 0/%h", seen, res32, 32'd14);
    end
    $display("flush of DIV done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [4:0] rdo; logic ena, hs, tmo; int lat, hc;
    @(negedge clk);
    start32 = 1'b1; f3_32 = 3'd0; a32 = 32'h1234; b32 = 32'h5678; rd32 = 5'd17;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (5) @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    n_checks++;
    if ({hold32, busy32, valid32, ena32} !== 4'b0000 || rdo32 !== 5'd0 || res32 !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid: got ctrl=%b rd=%0d res=%h expected all 0", {hold32, busy32, valid32, ena32}, rdo32, res32);
    end
    @(negedge clk);
    arst_n = 1'b1;
    run32(3'd0, 32'd3, 32'd4, 5'd8, res, rdo, ena, lat, hc, hs, tmo);
    n_checks++;
    if (tmo !== 1'b0 || res !== 32'd12 || rdo !== 5'd8) begin
      n_fail++; $display("FAIL reset_after_mul: got %h rd=%0d expected %h rd=8", res, rdo, 32'd12);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic [4:0] rdo; logic ena, hs, tmo; int lat, hc;
    run32(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd1, res, rdo, ena, lat, hc, hs, tmo);
    n_checks++;
    if (res !== 32'd1) begin
      n_fail++; $display("FAIL b2b_first: got %h expected %h", res, 32'd1);
    end
    // Started in the IDLE cycle directly after DONE.
    run32(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd2, res, rdo, ena, lat, hc, hs, tmo);
    n_checks++;
    if (res !== 32'hFFFF_FFFE || lat != 32 || hs !== 1'b1 || rdo !== 5'd2) begin
      n_fail++; $display("FAIL b2b_second: got %h lat=%0d hstart=%b rd=%0d expected %h/32/1/2", res, lat, hs, rdo, 32'hFFFF_FFFE);
    end
  endtask

  task automatic test_xlen64();
    logic [63:0] res, a, b, exp;
    logic [2:0]  f;
    logic        tmo, spec;
    int          lat;
    run64(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, res, lat, tmo);
    n_checks++;
    if (tmo !== 1'b0 || res !== 64'd1 || lat != 64) begin
      n_fail++; $display("FAIL x64_mulhu: got %h lat=%0d expected 1/64", res, lat);
    end
    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i == 0) begin f = 3'd6; b = 64'd0; end
      if (i == 1) begin f = 3'd4; a = 64'h8000_0000_0000_0000; b = '1; end
      if (i == 2) begin f = 3'd4; a = 64'hFFFF_FFFF_FFFF_FF00; b = 64'd9; end
      if (i == 3) begin f = 3'd2; a = 64'hFFFF_FFFF_FFFF_FFFF; end
      exp  = ref64(f, a, b);
      spec = f[2] && ((b == 64'd0) ||
             (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1));
      run64(f, a, b, 5'd6, res, lat, tmo);
      n_checks++;
      if (tmo !== 1'b0 || res !== exp) begin
        n_fail++; $display("FAIL x64_rand[%0d]: f3=%0d got %h expected %h", i, f, res, exp);
      end
      n_checks++;
      if (lat != (spec ? 0 : 64)) begin
        n_fail++; $display("FAIL x64_lat[%0d]: got %0d expected %0d", i, lat, spec ? 0 : 64);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_xlen64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
